fexp2_bf16: RTL and testbench
=============================

# fexp2_bf16

Iterative BFloat16 base-2 exponential unit computing 2^x. It is the inverse of the FLOG log2 datapath: it shares the same operand, result and valid handshake, so the same bench and scripts can round-trip log2 → exp2. It converts x to signed fixed point, splits it into integer part I and fraction F, and forms 2^F by one shift-and-multiply iteration per fraction bit. The result is packed as exponent I+127 with a round-to-nearest-even mantissa.

## Interface
- FXP_FRAC, 16: fraction bits of the internal fixed-point x; this is also the number of iterations.
- ACC_FRAC, 18: fraction bits of the Q1.ACC_FRAC accumulator.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- sign  in  S_WIDTH  operand sign.
- exponent  in  EXP_WIDTH  operand biased exponent.
- fractional  in  FRACT_WIDTH  operand mantissa, hidden bit excluded.
- valid_i  in  1  operand valid; level, held until valid_o has been seen.
- s_res_o  out  S_WIDTH  result sign; always 0 for computed results.
- e_res_o  out  EXP_WIDTH  result biased exponent.
- f_res_o  out  FRACT_WIDTH  result mantissa.
- valid_o  out  1  result valid.

## Operation
- **Reset values:** s_res_o=0, e_res_o=0, f_res_o=0, valid_o=0, state IDLE.
- **IDLE:** valid_i=1 captures sign, exponent and fractional into registers, then goes to CONVERT. Input changes after the capture edge are ignored.
- **CONVERT:** forms x = ±1.f·2^(e−127) as signed Q8.FXP_FRAC, truncating toward −inf.
  - I = arithmetic floor (x >> FXP_FRAC); F = low FXP_FRAC bits.
  - Accumulator acc = 1.0; then go to ITER with k=1.
  - Classification:
    - e=255 and f≠0 → QNaN (0,255,1000000).
    - +inf → +inf (0,255,0).
    - −inf → +0.
    - e=0 (zero or denormal, flushed) → 1.0 (0,127,0).
    - e<127−FXP_FRAC → F=0 and I=0 (or −1 if negative), so the result is ≈1.0.
    - e≥134 → overflow: positive → +inf, negative → +0.
- **ITER:** for k=1..FXP_FRAC, if F bit (FXP_FRAC−k) is set, acc = (acc·C_k) >> ACC_FRAC, truncated.
  - C_k = round(2^(2^−k)·2^ACC_FRAC).
  - k = FXP_FRAC goes to PACK.
- **PACK:**
  - Mantissa = acc[ACC_FRAC−1 : ACC_FRAC−7]; guard = next bit; sticky = OR of the bits below.
  - Apply round-to-nearest-even. A mantissa carry gives f=0 and I+1.
  - Biased exponent I+127 ≥255 → +inf; ≤0 → +0.
  - Specials override everything. Register the outputs, then go to DONE.
- **DONE:** valid_o=1 and outputs held while valid_i=1. valid_i sampled 0 → IDLE, and valid_o=0 after that edge.
- Outputs keep the last result in IDLE; only valid_o drops.

## Timing
- Let E0 be the capture edge. CONVERT→ITER at E1; ITER occupies E2..E(FXP_FRAC+1); PACK→DONE at E(FXP_FRAC+2).
- valid_o rises after edge E(FXP_FRAC+2), which is 18 edges at the default.
- valid_i deasserted mid-computation is ignored. The computation completes, and DONE then lasts exactly one cycle, so valid_o is a one-cycle pulse.
- valid_i already high on return to IDLE is a new request: capture occurs on the next edge, with one cycle of IDLE minimum.
- rst low at any time, including mid-ITER: immediate return to reset values; the partial result is discarded and no valid_o is produced.

## Configuration
- FEXP2_EARLY_EXIT_EN:
  - **Defined:** CONVERT goes straight to PACK for specials and when F=0. valid_o then rises after E2.
  - **Undefined:** fixed latency FXP_FRAC+2 for every operand; specials flow through ITER with acc ignored.
  - Result values are identical in both cases.

## Structure
- flog_pkg gains:
  - FXP_INT=8 and QNAN_FRACT=7'b1000000.
  - The fexp2 state enum typedef.
  - The existing S_WIDTH, EXP_WIDTH and FRACT_WIDTH are reused.
- Sub-module fexp2_lut: combinational ROM, k → C_k (ACC_FRAC+1 bits), entries computed from the parameters.

## Test plan
- (0,127,0000000) x=1.0 → (0,128,0000000); valid_o exactly 18 cycles after capture.
- (1,127,0000000) x=−1.0 → (0,126,0000000); (0,126,0000000) x=0.5 → (0,127,0110101), i.e. √2.
- Specials:
  - (0,255,0) → (0,255,0).
  - (1,255,0) → (0,0,0).
  - (0,255,1000000) → (0,255,1000000).
  - (0,0,0) → (0,127,0).
- Range: (0,134,0000000) x=128 → +inf; (1,134,0000010) x=−130 → +0; (0,133,1111110) x=127 → (0,254,0).
- Handshake:
  - valid_i dropped at E3 → single-cycle valid_o.
  - valid_i held → valid_o held with stable outputs until valid_i falls, then low one edge later.
- rst pulsed low at E8 → all outputs 0 immediately, no valid_o. A following request on x=1.0 is still correct. Run the full suite with and without FEXP2_EARLY_EXIT_EN; in early-exit mode, specials give valid_o after E2.

Source files
------------

// File: rtl/flog_pkg.sv
// Shared BFloat16 log2/exp2 definitions: operand widths, fixed-point formats,
// the fexp2 state encoding and the elaboration-time constants for the 2^(2^-k) ROM.
package flog_pkg;

    localparam int unsigned S_WIDTH     = 1;
    localparam int unsigned EXP_WIDTH   = 8;
    localparam int unsigned FRACT_WIDTH = 7;
    localparam int unsigned EXP_BIAS    = 127;

    localparam int unsigned FXP_INT  = 8;
    localparam int unsigned FXP_FRAC = 16;
    localparam int unsigned ACC_FRAC = 18;
    localparam int unsigned K_WIDTH  = $clog2(FXP_FRAC + 1);
    localparam int unsigned SQ_FRAC  = 30;

    localparam logic [FRACT_WIDTH-1:0] QNAN_FRACT = 7'b1000000;

    typedef enum logic [2:0] {
        FX_IDLE,
        FX_CONVERT,
        FX_ITER,
        FX_PACK,
        FX_DONE
    } fexp2_state_e;

    // Floor square root of a 64-bit integer (restoring digit-by-digit).
    function automatic logic [63:0] isqrt64(input logic [63:0] n);
        logic [63:0] op;
        logic [63:0] res;
        logic [63:0] one;
        op  = n;
        res = '0;
        one = 64'(1) << 62;
        for (int i = 0; i < 32; i++) begin
            if (op >= res + one) begin
                op  = op - (res + one);
                res = (res >> 1) + one;
            end else begin
                res = res >> 1;
            end
            one = one >> 2;
        end
        return res;
    endfunction

    // round(2^(2^-k) * 2^ACC_FRAC) via k repeated square roots of 2.0 at SQ_FRAC precision.
    function automatic logic [63:0] exp2_root_const(input int unsigned k);
        logic [63:0] v;
        v = 64'(2) << SQ_FRAC;
        for (int unsigned i = 0; i < k; i++) begin
            v = isqrt64(v << SQ_FRAC);
        end
        return (v + (64'(1) << (SQ_FRAC - ACC_FRAC - 1))) >> (SQ_FRAC - ACC_FRAC);
    endfunction

endpackage

// File: rtl/fexp2_lut.sv
// Combinational ROM: iteration index k -> C_k = round(2^(2^-k) * 2^ACC_FRAC).
module fexp2_lut
    import flog_pkg::*;
(
    input  logic [K_WIDTH-1:0]  i_k,
    output logic [ACC_FRAC:0]   o_coef_c
);

    logic [ACC_FRAC:0] w_tab [FXP_FRAC+1];

    assign w_tab[0] = '0;

    for (genvar g = 1; g <= FXP_FRAC; g++) begin : g_tab
        localparam logic [ACC_FRAC:0] C_K = (ACC_FRAC+1)'(exp2_root_const(g));
        assign w_tab[g] = C_K;
    end

    always_comb begin
        o_coef_c = '0;
        if (i_k <= K_WIDTH'(FXP_FRAC)) begin
            o_coef_c = w_tab[i_k];
        end
    end

endmodule

// File: rtl/fexp2_bf16.sv
// Iterative BFloat16 2^x unit (one shift-and-multiply per fraction bit).
// Optional macro FEXP2_EARLY_EXIT_EN: skip ITER for specials and integer x.
module fexp2_bf16
    import flog_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [S_WIDTH-1:0]     sign,
    input  logic [EXP_WIDTH-1:0]   exponent,
    input  logic [FRACT_WIDTH-1:0] fractional,
    input  logic                   valid_i,
    output logic [S_WIDTH-1:0]     s_res_o,
    output logic [EXP_WIDTH-1:0]   e_res_o,
    output logic [FRACT_WIDTH-1:0] f_res_o,
    output logic                   valid_o
);

    localparam int unsigned XW         = FXP_INT + FXP_FRAC;
    localparam int unsigned MW         = FRACT_WIDTH + 1;
    localparam int unsigned AW         = ACC_FRAC + 1;
    localparam int unsigned EW2        = EXP_WIDTH + 2;
    localparam int unsigned SHIFT_BASE = EXP_BIAS + FRACT_WIDTH - FXP_FRAC;
    localparam int unsigned OVF_EXP    = EXP_BIAS + FXP_INT - 1;
    localparam int unsigned GUARD_BIT  = ACC_FRAC - 1 - FRACT_WIDTH;
    localparam logic signed [EW2-1:0] BEXP_INF = EW2'((1 << EXP_WIDTH) - 1);

    fexp2_state_e r_state, w_next;

    logic                   r_sign;
    logic [EXP_WIDTH-1:0]   r_exp;
    logic [FRACT_WIDTH-1:0] r_frac;
    logic                   r_spec;
    logic [EXP_WIDTH-1:0]   r_spec_e;
    logic [FRACT_WIDTH-1:0] r_spec_f;
    logic signed [FXP_INT-1:0] r_int;
    logic [FXP_FRAC-1:0]    r_fbits;
    logic [AW-1:0]          r_acc;
    logic [K_WIDTH-1:0]     r_k;

    logic [MW-1:0]          w_m;
    logic [XW-1:0]          w_mag;
    logic [XW-1:0]          w_x;
    logic                   w_lost;
    logic                   w_spec;
    logic [EXP_WIDTH-1:0]   w_spec_e;
    logic [FRACT_WIDTH-1:0] w_spec_f;
    logic [AW-1:0]          w_coef;
    logic [FRACT_WIDTH-1:0] w_mant;
    logic                   w_guard;
    logic                   w_sticky;
    logic [FRACT_WIDTH:0]   w_mant_r;
    logic signed [EW2-1:0]  w_bexp;
    logic [EXP_WIDTH-1:0]   w_pe;
    logic [FRACT_WIDTH-1:0] w_pf;

    fexp2_lut u_lut (
        .i_k      (r_k),
        .o_coef_c (w_coef)
    );

    // Operand to signed Q8.16, floor rounding: negative values with lost bits step down one LSB.
    assign w_m = {1'b1, r_frac};

    always_comb begin
        w_mag  = '0;
        w_lost = 1'b0;
        if (r_exp >= EXP_WIDTH'(SHIFT_BASE)) begin
            w_mag = XW'(w_m) << (r_exp - EXP_WIDTH'(SHIFT_BASE));
        end else begin
            w_mag  = XW'(w_m) >> (EXP_WIDTH'(SHIFT_BASE) - r_exp);
            w_lost = (w_mag << (EXP_WIDTH'(SHIFT_BASE) - r_exp)) != XW'(w_m);
        end
        w_x = r_sign ? (XW'(0) - w_mag - XW'(w_lost)) : w_mag;
    end

    always_comb begin
        w_spec   = 1'b1;
        w_spec_e = '0;
        w_spec_f = '0;
        if (r_exp == '1) begin
            if (r_frac != '0) begin
                w_spec_e = '1;
                w_spec_f = QNAN_FRACT;
            end else if (!r_sign) begin
                w_spec_e = '1;
            end
        end else if (r_exp == '0) begin
            w_spec_e = EXP_WIDTH'(EXP_BIAS);
        end else if (r_exp >= EXP_WIDTH'(OVF_EXP)) begin
            if (!r_sign) begin
                w_spec_e = '1;
            end
        end else begin
            w_spec = 1'b0;
        end
    end

    // Round-to-nearest-even on the accumulator and exponent range clamp.
    always_comb begin
        w_mant   = r_acc[ACC_FRAC-1 -: FRACT_WIDTH];
        w_guard  = r_acc[GUARD_BIT];
        w_sticky = |r_acc[GUARD_BIT-1:0];
        w_mant_r = (FRACT_WIDTH+1)'(w_mant) + (FRACT_WIDTH+1)'(w_guard & (w_sticky | w_mant[0]));
        w_bexp   = EW2'(r_int) + EW2'(EXP_BIAS) + EW2'(w_mant_r[FRACT_WIDTH]);
        w_pe     = '0;
        w_pf     = '0;
        if (w_bexp >= BEXP_INF) begin
            w_pe = '1;
        end else if (w_bexp > EW2'(0)) begin
            w_pe = w_bexp[EXP_WIDTH-1:0];
            w_pf = w_mant_r[FRACT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FX_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            FX_IDLE:    if (valid_i) w_next = FX_CONVERT;
            FX_CONVERT: begin
`ifdef FEXP2_EARLY_EXIT_EN
                w_next = (w_spec || (w_x[FXP_FRAC-1:0] == '0)) ? FX_PACK : FX_ITER;
`else
                w_next = FX_ITER;
`endif
            end
            FX_ITER:    if (r_k == K_WIDTH'(FXP_FRAC)) w_next = FX_PACK;
            FX_PACK:    w_next = FX_DONE;
            FX_DONE:    if (!valid_i) w_next = FX_IDLE;
            default:    w_next = FX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sign   <= 1'b0;
            r_exp    <= '0;
            r_frac   <= '0;
            r_spec   <= 1'b0;
            r_spec_e <= '0;
            r_spec_f <= '0;
            r_int    <= '0;
            r_fbits  <= '0;
            r_acc    <= '0;
            r_k      <= '0;
            s_res_o  <= '0;
            e_res_o  <= '0;
            f_res_o  <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= (w_next == FX_DONE);
            case (r_state)
                FX_IDLE: begin
                    if (valid_i) begin
                        r_sign <= sign[0];
                        r_exp  <= exponent;
                        r_frac <= fractional;
                    end
                end
                FX_CONVERT: begin
                    r_spec   <= w_spec;
                    r_spec_e <= w_spec_e;
                    r_spec_f <= w_spec_f;
                    r_int    <= w_x[XW-1 -: FXP_INT];
                    r_fbits  <= w_x[FXP_FRAC-1:0];
                    r_acc    <= AW'(1) << ACC_FRAC;
                    r_k      <= K_WIDTH'(1);
                end
                FX_ITER: begin
                    if (r_fbits[FXP_FRAC-1]) begin
                        r_acc <= AW'(((2*AW)'(r_acc) * (2*AW)'(w_coef)) >> ACC_FRAC);
                    end
                    r_fbits <= r_fbits << 1;
                    r_k     <= r_k + K_WIDTH'(1);
                end
                FX_PACK: begin
                    s_res_o <= '0;
                    e_res_o <= r_spec ? r_spec_e : w_pe;
                    f_res_o <= r_spec ? r_spec_f : w_pf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fexp2_bf16.sv
// Scoreboard bench for fexp2_bf16: real-arithmetic reference model, randomized operands,
// handshake variants and mid-computation reset.
module tb_fexp2_bf16;

    logic       clk;
    logic       rst;
    logic [0:0] sign;
    logic [7:0] exponent;
    logic [6:0] fractional;
    logic       valid_i;
    logic [0:0] s_res_o;
    logic [7:0] e_res_o;
    logic [6:0] f_res_o;
    logic       valid_o;

    typedef struct {
        logic [7:0] e;
        logic [6:0] f;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   have;
    logic prev_v;
    int   checks;
    int   failures;

    fexp2_bf16 dut (
        .clk        (clk),
        .rst        (rst),
        .sign       (sign),
        .exponent   (exponent),
        .fractional (fractional),
        .valid_i    (valid_i),
        .s_res_o    (s_res_o),
        .e_res_o    (e_res_o),
        .f_res_o    (f_res_o),
        .valid_o    (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 2^x from the real value of x; the fraction power uses the rounded 2^(2^-k) constants.
    function automatic void model(input logic s, input logic [7:0] e, input logic [6:0] f,
                                  output exp_t r, output int lat);
        real    x;
        longint xi, ii, fi, acc, ck, mant, rem, be;
        lat = 18;
        r.e = 8'd0;
        r.f = 7'd0;
        if (e == 8'd255) begin
            if (f != 7'd0) begin r.e = 8'd255; r.f = 7'b1000000; end
            else if (!s)   r.e = 8'd255;
            lat = 2;
        end else if (e == 8'd0) begin
            r.e = 8'd127;
            lat = 2;
        end else begin
            x = (128.0 + real'(f)) / 128.0 * (2.0 ** (real'(e) - 127.0));
            if (s) x = -x;
            if (x >= 128.0 || x <= -128.0) begin
                if (!s) r.e = 8'd255;
                lat = 2;
            end else begin
                xi  = longint'($floor(x * 65536.0));
                ii  = longint'($floor(x));
                fi  = xi - ii * 65536;
                acc = 262144;
                for (int k = 1; k <= 16; k++) begin
                    ck = longint'($rtoi((2.0 ** (2.0 ** (-real'(k)))) * 262144.0 + 0.5));
                    if (((fi >> (16 - k)) & 1) == 1) acc = (acc * ck) >> 18;
                end
                mant = (acc - 262144) >> 11;
                rem  = acc & 2047;
                if (rem > 1024 || (rem == 1024 && (mant & 1) == 1)) mant = mant + 1;
                if (mant == 128) begin mant = 0; ii = ii + 1; end
                be = ii + 127;
                if (be >= 255)   r.e = 8'd255;
                else if (be > 0) begin r.e = 8'(be); r.f = 7'(mant); end
                if (fi == 0) lat = 2;
            end
        end
`ifndef FEXP2_EARLY_EXIT_EN
        lat = 18;
`endif
    endfunction

    // Monitor: pops one expectation per valid_o rising edge, checks every valid cycle.
    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 1'b0;
            have   = 1'b0;
        end else begin
            if (valid_o && !prev_v) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    have = 1'b0;
                    $display("FAIL unexpected_valid got=(%0d,%0d,%0d) expected no result",
                             s_res_o, e_res_o, f_res_o);
                end else begin
                    cur  = q.pop_front();
                    have = 1'b1;
                end
            end
            if (valid_o && have) begin
                checks++;
                if (s_res_o != 1'b0 || e_res_o != cur.e || f_res_o != cur.f) begin
                    failures++;
                    $display("FAIL result got=(%0d,%0d,%b) expected=(0,%0d,%b)",
                             s_res_o, e_res_o, f_res_o, cur.e, cur.f);
                end
            end
            prev_v = valid_o;
        end
    end

    // mode 0: drop valid_i on valid_o; 1: hold 1..3 extra cycles; 2: drop at E3.
    task automatic run_req(input logic s, input logic [7:0] e, input logic [6:0] f, input int mode);
        exp_t r;
        int   lat, n, h;
        bit   seen;
        model(s, e, f, r, lat);
        q.push_back(r);
        @(negedge clk);
        sign = s; exponent = e; fractional = f; valid_i = 1'b1;
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (valid_o) seen = 1'b1;
            else begin
                if (n == 1) begin
                    sign = 1'($urandom); exponent = 8'($urandom); fractional = 7'($urandom);
                end
                if (mode == 2 && n == 3) valid_i = 1'b0;
            end
        end
        checks++;
        if (!seen || n != lat) begin
            failures++;
            $display("FAIL latency op=(%0d,%0d,%b) got=%0d expected=%0d", s, e, f, n, lat);
        end
        if (!seen) begin
            valid_i = 1'b0;
            q.delete();
            repeat (25) @(posedge clk);
            return;
        end
        if (mode == 1) begin
            h = $urandom_range(1, 3);
            repeat (h) begin
                @(posedge clk);
                #1;
                checks++;
                if (!valid_o) begin
                    failures++;
                    $display("FAIL valid_hold got=%0d expected=1", valid_o);
                end
            end
        end
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (valid_o || e_res_o != r.e || f_res_o != r.f) begin
            failures++;
            $display("FAIL valid_drop got v=%0d (%0d,%b) expected v=0 (%0d,%b)",
                     valid_o, e_res_o, f_res_o, r.e, r.f);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rs_e;
        checks = 0; failures = 0;
        rst = 1'b0; valid_i = 1'b0; sign = '0; exponent = '0; fractional = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (valid_o || s_res_o != 0 || e_res_o != 0 || f_res_o != 0) begin
            failures++;
            $display("FAIL reset_state got v=%0d (%0d,%0d,%0d) expected all 0",
                     valid_o, s_res_o, e_res_o, f_res_o);
        end
        @(negedge clk) rst = 1'b1;

        run_req(1'b0, 8'd127, 7'd0,   0);
        run_req(1'b1, 8'd127, 7'd0,   1);
        run_req(1'b0, 8'd126, 7'd0,   2);
        run_req(1'b0, 8'd255, 7'd0,   0);
        run_req(1'b1, 8'd255, 7'd0,   0);
        run_req(1'b0, 8'd255, 7'd64,  1);
        run_req(1'b0, 8'd0,   7'd0,   0);
        run_req(1'b1, 8'd0,   7'd3,   0);
        run_req(1'b0, 8'd134, 7'd0,   0);
        run_req(1'b1, 8'd134, 7'd2,   0);
        run_req(1'b0, 8'd133, 7'd126, 2);
        run_req(1'b1, 8'd100, 7'd5,   0);
        run_req(1'b0, 8'd100, 7'd5,   0);
        run_req(1'b1, 8'd115, 7'd77,  1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) rs_e = 8'($urandom);
            else                           rs_e = 8'($urandom_range(108, 135));
            run_req(1'($urandom), rs_e, 7'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset mid-ITER: outputs clear at once and the aborted result never appears.
        @(negedge clk);
        sign = 1'b0; exponent = 8'd126; fractional = 7'd0; valid_i = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (valid_o || s_res_o != 0 || e_res_o != 0 || f_res_o != 0) begin
            failures++;
            $display("FAIL async_reset got v=%0d (%0d,%0d,%0d) expected all 0",
                     valid_o, s_res_o, e_res_o, f_res_o);
        end
        valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (25) @(posedge clk);
        run_req(1'b0, 8'd127, 7'd0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_results got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
